bit_compare_inv: RTL and testbench

- Registered magnitude comparator for two WIDTH-bit operands, a and b.
- Produces four one-hot-style relation flags: c = equal, d = not-equal, e = greater-than, f = less-than.
- Default WIDTH=1 gives the classic 1-bit compare: c = XNOR, d = XOR, e = a AND NOT b, f = NOT a AND b.
- Sits as a leaf datapath block feeding control/decision logic; one-cycle latency with a valid qualifier.

---
 rtl/bit_compare_pkg.sv | 20 ++
 rtl/bit_cmp_slice.sv | 20 ++
 rtl/bit_compare_inv.sv | 98 +++++++++
 tb/tb_bit_compare_inv.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_compare_pkg.sv
// Shared types and helpers for the bit_compare_inv registered magnitude comparator.
package bit_compare_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    typedef struct packed {
        logic eq;
        logic ne;
        logic gt;
        logic lt;
    } cmp_flags_t;

    // Bitwise complement of all four flags when inv is set (active-low output mode).
    function automatic cmp_flags_t flags_invert(input cmp_flags_t flags, input logic inv);
        cmp_flags_t res;
        res = inv ? cmp_flags_t'(~flags) : flags;
        return res;
    endfunction

endpackage

// File: rtl/bit_cmp_slice.sv
// One bit of an MSB-first magnitude compare chain: keeps the upstream decision or
// decides on this bit when the higher bits were equal.
module bit_cmp_slice (
    input  logic a_i,
    input  logic b_i,
    input  logic gt_in,
    input  logic lt_in,
    output logic gt_out,
    output logic lt_out
);

    logic undecided;

    always_comb begin
        undecided = ~(gt_in | lt_in);
        gt_out    = gt_in | (undecided & a_i & ~b_i);
        lt_out    = lt_in | (undecided & ~a_i & b_i);
    end

endmodule

// File: rtl/bit_compare_inv.sv
// Registered WIDTH-bit comparator producing eq/ne/gt/lt flags with one-cycle latency,
// optional two's-complement compare and optional active-low flag outputs.
module bit_compare_inv
    import bit_compare_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter bit          SIGNED = 1'b0,
    parameter bit          INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             c,
    output logic             d,
    output logic             e,
    output logic             f
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam cmp_flags_t RST_FLAGS = flags_invert(cmp_flags_t'(4'b0000), INVERT);

    cmp_flags_t flags_c;
    cmp_flags_t flags_d;
    cmp_flags_t flags_q;
    logic       valid_d;
    logic       valid_q;

    // MSB-first chain; in signed mode the sign bit compares with operands swapped,
    // so a set sign bit makes that operand the smaller one.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic a_bit;
        logic b_bit;
        logic gt_up;
        logic lt_up;
        logic gt_o;
        logic lt_o;

        if (SIGNED && (i == MSB)) begin : g_sign
            assign a_bit = b[i];
            assign b_bit = a[i];
        end else begin : g_mag
            assign a_bit = a[i];
            assign b_bit = b[i];
        end

        if (i == MSB) begin : g_top
            assign gt_up = 1'b0;
            assign lt_up = 1'b0;
        end else begin : g_link
            assign gt_up = g_bit[i+1].gt_o;
            assign lt_up = g_bit[i+1].lt_o;
        end

        bit_cmp_slice u_slice (
            .a_i    (a_bit),
            .b_i    (b_bit),
            .gt_in  (gt_up),
            .lt_in  (lt_up),
            .gt_out (gt_o),
            .lt_out (lt_o)
        );
    end

    // Flag derivation; flags hold when no sample is accepted so idle inputs never reach the outputs.
    always_comb begin
        flags_c    = cmp_flags_t'(4'b0000);
        flags_c.gt = g_bit[0].gt_o;
        flags_c.lt = g_bit[0].lt_o;
        flags_c.ne = g_bit[0].gt_o | g_bit[0].lt_o;
        flags_c.eq = ~(g_bit[0].gt_o | g_bit[0].lt_o);

        valid_d = in_valid;
        flags_d = flags_q;
        if (in_valid) begin
            flags_d = flags_invert(flags_c, INVERT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            flags_q <= RST_FLAGS;
        end else begin
            valid_q <= valid_d;
            flags_q <= flags_d;
        end
    end

    assign out_valid = valid_q;
    assign c         = flags_q.eq;
    assign d         = flags_q.ne;
    assign e         = flags_q.gt;
    assign f         = flags_q.lt;

endmodule

// File: tb/tb_bit_compare_inv.sv
// Scoreboard bench: six comparator configurations share one stimulus stream and are
// checked against an arithmetic reference model by an independent monitor.
module tb_bit_compare_inv;

    localparam int NI = 6;
    localparam int unsigned CW [NI] = '{1, 8, 8, 1, 16, 16};
    localparam bit          CS [NI] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam bit          CI [NI] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    typedef struct packed {
        int              due;
        logic [NI-1:0][3:0] fl;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [15:0]   a_v;
    logic [15:0]   b_v;
    logic [NI-1:0] ov_w, c_w, d_w, e_w, f_w;

    exp_t                 exp_q [$];
    logic [NI-1:0][3:0]   held;
    int                   cyc;
    int                   checks;
    int                   errors;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned W = CW[g];
        bit_compare_inv #(.WIDTH(W), .SIGNED(CS[g]), .INVERT(CI[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .a         (a_v[W-1:0]),
            .b         (b_v[W-1:0]),
            .out_valid (ov_w[g]),
            .c         (c_w[g]),
            .d         (d_w[g]),
            .e         (e_w[g]),
            .f         (f_w[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: interpret operands as integers of the configured width and compare.
    function automatic logic [3:0] model(input logic [15:0] av, input logic [15:0] bv,
                                         input int w, input bit sgn, input bit inv);
        longint x, y, m;
        logic [3:0] r;
        m = (longint'(1) << w) - 1;
        x = longint'(av) & m;
        y = longint'(bv) & m;
        if (sgn && av[w-1]) x = x - (longint'(1) << w);
        if (sgn && bv[w-1]) y = y - (longint'(1) << w);
        r = {x == y, x != y, x > y, x < y};
        return inv ? ~r : r;
    endfunction

    function automatic logic [NI-1:0][3:0] reset_vals();
        logic [NI-1:0][3:0] r;
        for (int i = 0; i < NI; i++) r[i] = CI[i] ? 4'hF : 4'h0;
        return r;
    endfunction

    function automatic logic [3:0] dut_flags(input int i);
        return {c_w[i], d_w[i], e_w[i], f_w[i]};
    endfunction

    // Drive one stimulus cycle; accepted samples enter the scoreboard.
    task automatic issue(input logic v, input logic [15:0] av, input logic [15:0] bv);
        exp_t ent;
        @(negedge clk);
        in_valid = v;
        a_v      = av;
        b_v      = bv;
        if (v) begin
            ent.due = cyc + 1;
            for (int i = 0; i < NI; i++) ent.fl[i] = model(av, bv, CW[i], CS[i], CI[i]);
            exp_q.push_back(ent);
        end
    endtask

    // Monitor: compares outputs against the scoreboard away from the active edge.
    initial begin
        exp_t ent;
        logic [3:0] got, raw;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    ent = exp_q.pop_front();
                    checks++;
                    if (ov_w !== {NI{1'b1}}) begin
                        errors++;
                        $display("FAIL valid_latency cyc=%0d out_valid=%b expected=%b", cyc, ov_w, {NI{1'b1}});
                    end
                    for (int i = 0; i < NI; i++) begin
                        got = dut_flags(i);
                        checks++;
                        if (got !== ent.fl[i]) begin
                            errors++;
                            $display("FAIL flags inst=%0d cyc=%0d got cdef=%b expected=%b", i, cyc, got, ent.fl[i]);
                        end
                        raw = CI[i] ? ~got : got;
                        checks++;
                        if ((raw[3] + raw[1] + raw[0]) != 1 || raw[2] !== ~raw[3]) begin
                            errors++;
                            $display("FAIL invariant inst=%0d cyc=%0d cdef=%b", i, cyc, got);
                        end
                        held[i] = ent.fl[i];
                    end
                end else begin
                    checks++;
                    if (ov_w !== '0) begin
                        errors++;
                        $display("FAIL idle_valid cyc=%0d out_valid=%b expected=0", cyc, ov_w);
                    end
                    for (int i = 0; i < NI; i++) begin
                        checks++;
                        if (dut_flags(i) !== held[i]) begin
                            errors++;
                            $display("FAIL hold inst=%0d cyc=%0d got cdef=%b expected=%b", i, cyc, dut_flags(i), held[i]);
                        end
                    end
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        logic [NI-1:0][3:0] rv;
        rv = reset_vals();
        checks++;
        if (ov_w !== '0) begin
            errors++;
            $display("FAIL %s_valid out_valid=%b expected=0", tag, ov_w);
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (dut_flags(i) !== rv[i]) begin
                errors++;
                $display("FAIL %s_flags inst=%0d got cdef=%b expected=%b", tag, i, dut_flags(i), rv[i]);
            end
        end
    endtask

    logic [15:0] dir_a [10] = '{16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h00FF,
                                16'h007F, 16'h005A, 16'h0080, 16'h00FF, 16'hFFFF};
    logic [15:0] dir_b [10] = '{16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0001,
                                16'h0080, 16'h005A, 16'h007F, 16'h00FE, 16'h0000};

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        in_valid = 1'b0;
        a_v      = '0;
        b_v      = '0;
        held     = reset_vals();
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: 1-bit toggle pattern and the multi-bit boundary cases.
        for (int k = 0; k < 10; k++) issue(1'b1, dir_a[k], dir_b[k]);

        // INVERT hold case: accept a=1,b=0 then idle with random operands.
        issue(1'b1, 16'h0001, 16'h0000);
        for (int k = 0; k < 4; k++) issue(1'b0, 16'($urandom), 16'($urandom));

        // Mid-stream asynchronous reset discards the in-flight result.
        issue(1'b1, 16'h1234, 16'h4321);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("mid_reset");
        exp_q.delete();
        held     = reset_vals();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b1, 16'h0001, 16'h0001);

        // Randomised traffic with occasional idle cycles and biased equal operands.
        for (int k = 0; k < 1000; k++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
            issue(($urandom_range(0, 4) != 0), ra, rb);
        end
        issue(1'b0, 16'h0, 16'h0);
        issue(1'b0, 16'h0, 16'h0);
        @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
